// File: rtl/audio_pkg.sv
// Shared constants, state encoding and helpers for the audio processor.
// AUDIO_PITCH_SHIFT_EN adds the semitone-to-ratio table.
package audio_pkg;
  localparam int SAMPLES      = 2048;
  localparam int LINE_SAMPLES = 32;
  localparam int LINES        = 64;
  localparam int SAMPLE_W     = 16;
  localparam int IDX_W        = 11;
  localparam int PHASE_W      = 23;  // Q11.12
  localparam int RATIO_W      = 14;
  localparam int LINE_W       = LINE_SAMPLES * SAMPLE_W;
  localparam logic [7:0] COEFF_ONE = 8'h80;
  localparam logic [RATIO_W-1:0] RATIO_ONE = 14'd4096;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  typedef struct packed {
    logic [IDX_W-1:0]           n;
    logic signed [SAMPLE_W-1:0] sample;
    logic [7:0]                 coeff;
  } rd_stage_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [23:0] p);
    logic signed [23:0] s;
    s = (p + 24'sd64) >>> 7;
    if (s > 24'sd32767)       return 16'sh7fff;
    else if (s < -24'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction

`ifdef AUDIO_PITCH_SHIFT_EN
  // round(4096 * 2^(s/12)), entry 0 is s = -16
  localparam logic [RATIO_W-1:0] RATIO_TAB [32] = '{
    14'd1625, 14'd1722, 14'd1825, 14'd1933, 14'd2048, 14'd2170, 14'd2299, 14'd2435,
    14'd2580, 14'd2734, 14'd2896, 14'd3069, 14'd3251, 14'd3444, 14'd3649, 14'd3866,
    14'd4096, 14'd4340, 14'd4598, 14'd4871, 14'd5161, 14'd5468, 14'd5793, 14'd6137,
    14'd6502, 14'd6889, 14'd7298, 14'd7732, 14'd8192, 14'd8679, 14'd9195, 14'd9742};

  function automatic logic [RATIO_W-1:0] ratio_of(input logic signed [4:0] s);
    return RATIO_TAB[{~s[4], s[3:0]}];
  endfunction
`endif
endpackage

// File: rtl/audio_processor_pitch_resampler.sv
// Phase accumulator producing the input-sample index for each issued output sample.
// AUDIO_PITCH_SHIFT_EN enables the semitone latch and ratio lookup; otherwise ratio is 1.0.
module pitch_resampler
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic              semi_wr_en,
  input  logic signed [4:0] semi_in,
  output logic [IDX_W-1:0]  idx
);
  logic [PHASE_W-1:0] phase;
  logic [RATIO_W-1:0] ratio;

`ifdef AUDIO_PITCH_SHIFT_EN
  logic signed [4:0] semi_q;

  // ratio is frozen at start so mid-run semitone writes only affect the next run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      semi_q <= '0;
      ratio  <= RATIO_ONE;
    end else begin
      if (semi_wr_en) semi_q <= semi_in;
      if (clear)      ratio  <= ratio_of(semi_q);
    end
  end
`else
  logic unused_semi;
  assign unused_semi = ^{semi_wr_en, semi_in};
  assign ratio = RATIO_ONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       phase <= '0;
    else if (clear)   phase <= '0;
    else if (advance) phase <= phase + PHASE_W'(ratio);
  end

  assign idx = phase[PHASE_W-1 -: IDX_W];
endmodule

// File: rtl/audio_processor.sv
// Line-buffered resample + per-sample gain engine: 2048 samples per run, 3-stage datapath.
// Build option AUDIO_PITCH_SHIFT_EN enables semitone pitch shift.
module audio_processor
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_wr_en,
  input  logic [5:0]        input_index,
  input  logic [LINE_W-1:0] data_in,
  input  logic              pitch_shift_wr_en,
  input  logic signed [4:0] pitch_shift_semitones,
  input  logic              freq_coeff_wr_en,
  input  logic [10:0]       freq_coeff_index,
  input  logic [7:0]        freq_coeff_in,
  input  logic [5:0]        output_index,
  output logic [LINE_W-1:0] data_out
);
  localparam int STAGES = 2;

  state_e                                   state;
  logic [IDX_W-1:0]                         n;
  logic [1:0]                               flush_cnt;
  logic [LINE_SAMPLES-1:0][SAMPLE_W-1:0]    in_mem  [LINES];
  logic [LINE_SAMPLES-1:0][SAMPLE_W-1:0]    out_mem [LINES];
  logic [7:0]                               coeff_mem [SAMPLES];
  logic [SAMPLES-1:0]                       coeff_vld;
  logic [STAGES:0]                          vld_pipe;
  rd_stage_t                                rd_q;
  logic signed [23:0]                       prod_q;
  logic signed [SAMPLE_W-1:0]               sat_q;
  logic [IDX_W-1:0]                         n_p1, n_p2;
  logic [IDX_W-1:0]                         rd_idx;
  logic                                     idle, issue, go;

  assign idle  = (state == IDLE);
  assign issue = (state == RUN);
  assign go    = idle & start;

  pitch_resampler u_resamp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (go),
    .advance    (issue),
    .semi_wr_en (pitch_shift_wr_en),
    .semi_in    (pitch_shift_semitones),
    .idx        (rd_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          n     <= '0;
        end
        RUN: begin
          n <= n + 1'b1;
          if (n == IDX_W'(SAMPLES - 1)) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == 2'd2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // only the valids are reset; a reset mid-run therefore drops in-flight samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      coeff_vld <= '0;
      data_out  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      if (freq_coeff_wr_en && idle) coeff_vld[freq_coeff_index] <= 1'b1;
      data_out <= out_mem[output_index];
    end
  end

  always_ff @(posedge clk) begin
    rd_q.n      <= n;
    rd_q.sample <= in_mem[rd_idx[10:5]][rd_idx[4:0]];
    rd_q.coeff  <= coeff_vld[n] ? coeff_mem[n] : COEFF_ONE;
    prod_q      <= 24'($signed(rd_q.sample)) * 24'($signed({1'b0, rd_q.coeff}));
    n_p1        <= rd_q.n;
    sat_q       <= sat16(prod_q);
    n_p2        <= n_p1;
    if (vld_pipe[STAGES])             out_mem[n_p2[10:5]][n_p2[4:0]] <= sat_q;
    if (data_wr_en && idle)           in_mem[input_index] <= data_in;
    if (freq_coeff_wr_en && idle)     coeff_mem[freq_coeff_index] <= freq_coeff_in;
  end
endmodule

// File: tb/tb_audio_processor.sv
// Scoreboard bench for audio_processor: expected samples queued at stimulus, popped at readback.
module tb_audio_processor;
  import audio_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, start, data_wr_en, pitch_shift_wr_en, freq_coeff_wr_en;
  logic [5:0]        input_index, output_index;
  logic [LINE_W-1:0] data_in, data_out;
  logic signed [4:0] pitch_shift_semitones;
  logic [10:0]       freq_coeff_index;
  logic [7:0]        freq_coeff_in;

  always #5 clk = ~clk;

  audio_processor dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .data_wr_en            (data_wr_en),
    .input_index           (input_index),
    .data_in               (data_in),
    .pitch_shift_wr_en     (pitch_shift_wr_en),
    .pitch_shift_semitones (pitch_shift_semitones),
    .freq_coeff_wr_en      (freq_coeff_wr_en),
    .freq_coeff_index      (freq_coeff_index),
    .freq_coeff_in         (freq_coeff_in),
    .output_index          (output_index),
    .data_out              (data_out)
  );

  logic [15:0] in_m    [SAMPLES];
  logic [7:0]  coeff_m [SAMPLES];
  bit          cvld    [SAMPLES];
  int          semi_m;
  logic [15:0] exp_q[$];
  logic [15:0] last_out;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int bench_ratio(input int s);
`ifdef AUDIO_PITCH_SHIFT_EN
    return $rtoi(4096.0 * (2.0 ** (real'(s) / 12.0)) + 0.5);
`else
    return 4096;
`endif
  endfunction

  function automatic logic [15:0] model(input int n, input int ratio);
    longint ph;
    int idx, x, c, r;
    ph  = (longint'(n) * longint'(ratio)) % 64'sd8388608;
    idx = int'(ph >> 12);
    x   = int'($signed(in_m[idx]));
    c   = cvld[n] ? int'(coeff_m[n]) : 128;
    r   = (x * c + 64) >>> 7;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic push_expected();
    int ratio;
    ratio = bench_ratio(semi_m);
    for (int i = 0; i < SAMPLES; i++) exp_q.push_back(model(i, ratio));
  endtask

  task automatic load_input();
    for (int l = 0; l < LINES; l++) begin
      @(negedge clk);
      data_wr_en  = 1'b1;
      input_index = 6'(l);
      for (int k = 0; k < LINE_SAMPLES; k++) data_in[16*k +: 16] = in_m[32*l + k];
    end
    @(negedge clk) data_wr_en = 1'b0;
  endtask

  task automatic wr_coeff(input int i, input logic [7:0] v);
    @(negedge clk);
    freq_coeff_wr_en = 1'b1; freq_coeff_index = 11'(i); freq_coeff_in = v;
    @(negedge clk) freq_coeff_wr_en = 1'b0;
    coeff_m[i] = v; cvld[i] = 1'b1;
  endtask

  task automatic wr_semi(input int s);
    @(negedge clk);
    pitch_shift_wr_en = 1'b1; pitch_shift_semitones = 5'(s);
    @(negedge clk) pitch_shift_wr_en = 1'b0;
    semi_m = s;
  endtask

  task automatic read_line(input int l, output logic [LINE_W-1:0] v);
    @(negedge clk) output_index = 6'(l);
    @(negedge clk) v = data_out;
  endtask

  // restart_at / busy_at: cycle offsets after the start edge (-1 = unused)
  task automatic run(input string tag, input int restart_at, input int busy_at, input bit chk_done);
    logic [15:0]       new_last;
    logic [LINE_W-1:0] exp_line, got;
    new_last = exp_q[$];
    output_index = 6'd63;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 2055; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == busy_at) begin
        data_wr_en = 1'b1; input_index = 6'd3; data_in = '1;
        freq_coeff_wr_en = 1'b1; freq_coeff_index = 11'd1000; freq_coeff_in = 8'h00;
        pitch_shift_wr_en = 1'b1; pitch_shift_semitones = 5'sd7;
      end else begin
        data_wr_en = 1'b0; freq_coeff_wr_en = 1'b0; pitch_shift_wr_en = 1'b0;
      end
      if (chk_done && k == 2051) chk({tag, " last sample before done"}, LINE_W'(data_out[511:496]), LINE_W'(last_out));
      if (chk_done && k == 2052) chk({tag, " last sample at done"}, LINE_W'(data_out[511:496]), LINE_W'(new_last));
    end
    if (busy_at >= 0) semi_m = 7;
    for (int l = 0; l < LINES; l++) begin
      for (int k = 0; k < LINE_SAMPLES; k++) exp_line[16*k +: 16] = exp_q.pop_front();
      read_line(l, got);
      chk($sformatf("%s line %0d", tag, l), got, exp_line);
    end
    last_out = new_last;
  endtask

  initial begin
    logic [LINE_W-1:0] v;
    rst_n = 1'b0; start = 1'b0; data_wr_en = 1'b0; pitch_shift_wr_en = 1'b0; freq_coeff_wr_en = 1'b0;
    input_index = '0; output_index = '0; data_in = '0; pitch_shift_semitones = '0;
    freq_coeff_index = '0; freq_coeff_in = '0; semi_m = 0;
    for (int i = 0; i < SAMPLES; i++) begin cvld[i] = 1'b0; coeff_m[i] = 8'h00; end
    repeat (3) @(negedge clk);
    chk("reset data_out", data_out, '0);
    rst_n = 1'b1;

    // sine passthrough
    for (int i = 0; i < SAMPLES; i++)
      in_m[i] = 16'($rtoi(500.0 * $sin(2.0 * 3.141592653589793 * 50.0 * real'(i) / 2048.0)));
    load_input(); wr_semi(0); push_expected();
    run("sine", -1, -1, 1'b0);
    read_line(0, v);
    chk("sine sample0", LINE_W'(v[15:0]), LINE_W'(16'd0));
    chk("sine sample1", LINE_W'(v[31:16]), LINE_W'(16'd76));

    // pitch shift up/down an octave on a ramp
    for (int i = 0; i < SAMPLES; i++) in_m[i] = 16'(i);
    load_input(); wr_semi(12); push_expected();
    run("up12", -1, -1, 1'b0);
    read_line(0, v);
`ifdef AUDIO_PITCH_SHIFT_EN
    chk("up12 sample3", LINE_W'(v[63:48]), LINE_W'(16'd6));
`else
    chk("up12 sample3", LINE_W'(v[63:48]), LINE_W'(16'd3));
`endif
    wr_semi(-12); push_expected();
    run("down12", -1, -1, 1'b0);
    read_line(0, v);
`ifdef AUDIO_PITCH_SHIFT_EN
    chk("down12 sample3", LINE_W'(v[63:48]), LINE_W'(16'd1));
`else
    chk("down12 sample3", LINE_W'(v[63:48]), LINE_W'(16'd3));
`endif

    // gain coefficients, ignored restart, busy-time writes, completion timing
    wr_semi(0); wr_coeff(5, 8'h00); wr_coeff(2047, 8'h40); push_expected();
    run("coeff", 100, 50, 1'b1);
    read_line(0, v);
    chk("coeff sample5", LINE_W'(v[95:80]), LINE_W'(16'd0));
    chk("coeff sample4", LINE_W'(v[79:64]), LINE_W'(16'd4));

    // saturation both ways
    wr_semi(0);
    in_m[0] = 16'sh7fff; in_m[1] = 16'(-1000);
    load_input(); wr_coeff(0, 8'hff); wr_coeff(1, 8'h40); push_expected();
    run("satpos", -1, -1, 1'b0);
    read_line(0, v);
    chk("satpos sample0", LINE_W'(v[15:0]), LINE_W'(16'h7fff));
    in_m[0] = 16'sh8000;
    load_input(); push_expected();
    run("satneg", -1, -1, 1'b0);
    read_line(0, v);
    chk("satneg sample0", LINE_W'(v[15:0]), LINE_W'(16'h8000));

    // reset mid-run aborts; next start runs a fresh identity pass
    output_index = 6'd0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrun reset data_out", data_out, '0);
    for (int i = 0; i < SAMPLES; i++) cvld[i] = 1'b0;
    semi_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_expected();
    run("after reset", -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
